// File: rtl/systolic_os_sequencer.sv
// systolic_os_sequencer: tile-loop control sequencer for the systolic_system output-stationary datapath
// Ports:
//   clk, reset (sync, active-low)
//   start, K, tile_rows, tile_cols, num_row_tiles, num_col_tiles, bias_en : job config, sampled in IDLE
//   bias_valid, bias_data -> bias_ready : bias word stream, replayed as w_en_bias/w_index_bias/w_data_bias
//   hold : stall at tile boundary; abort : return to IDLE
//   mode, a_buf_on, w_buf_on, a/w/o_base_addr, a_num_rows, w_num_cols, operation_signal_in, o_ag_o_on : datapath controls
//   busy, done, err : status
module systolic_os_sequencer #(
    parameter int ARRAY_N      = 16,
    parameter int ARRAY_M      = 16,
    parameter int PE_OUT_WIDTH = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int OBUF_DELAY   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [31:0]                K,
    input  logic [$clog2(ARRAY_N):0]   tile_rows,
    input  logic [$clog2(ARRAY_M):0]   tile_cols,
    input  logic [7:0]                 num_row_tiles,
    input  logic [7:0]                 num_col_tiles,
    input  logic                       bias_en,
    input  logic                       bias_valid,
    input  logic [PE_OUT_WIDTH-1:0]    bias_data,
    output logic                       bias_ready,
    input  logic                       hold,
    input  logic                       abort,
    output logic                       mode,
    output logic                       a_buf_on,
    output logic                       w_buf_on,
    output logic [ADDR_WIDTH-1:0]      a_base_addr,
    output logic [ADDR_WIDTH-1:0]      w_base_addr,
    output logic [ADDR_WIDTH-1:0]      o_base_addr,
    output logic [$clog2(ARRAY_N):0]   a_num_rows,
    output logic [$clog2(ARRAY_M):0]   w_num_cols,
    output logic [2:0]                 operation_signal_in,
    output logic [$clog2(ARRAY_M):0]   w_index_bias,
    output logic [PE_OUT_WIDTH-1:0]    w_data_bias,
    output logic                       w_en_bias,
    output logic                       o_ag_o_on,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int CW = $clog2(ARRAY_M) + 1;
    localparam int AW = ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, BIAS, FEED, FLUSH, DRAIN_WAIT, DRAIN_STORE, NEXT, DONE} state_t;

    state_t          state_q, state_d, feed_entry;
    logic [31:0]     cnt_q, k_q, rows32, cols32, flush_len, dw_len, ds_len;
    logic [7:0]      nrt_q, nct_q, row_idx, col_idx;
    logic [CW-1:0]   bias_cnt;
    logic            illegal, bias_acc, last_tile;

    // a_num_rows / w_num_cols double as the latched tile shape
    assign rows32     = 32'(a_num_rows);
    assign cols32     = 32'(w_num_cols);
    assign flush_len  = rows32 + cols32 - 32'd1;
    assign dw_len     = (rows32 + 32'd1 >= 32'(ARRAY_N)) ? 32'd0 : 32'(ARRAY_N) - rows32 - 32'd1;
    assign ds_len     = rows32 + 32'd1 + 32'(OBUF_DELAY);
    assign feed_entry = (k_q == 32'd0) ? FLUSH : FEED;
    assign last_tile  = (row_idx == nrt_q - 8'd1) && (col_idx == nct_q - 8'd1);
    assign bias_acc   = (state_q == BIAS) && bias_valid && !abort;
    assign illegal    = (tile_rows == '0) || (tile_cols == '0) || (num_row_tiles == 8'd0) ||
                        (num_col_tiles == 8'd0) || (32'(tile_rows) > 32'(ARRAY_N)) ||
                        (32'(tile_cols) > 32'(ARRAY_M));

    // cnt_q restarts at 0 on every state change, so a phase of length L ends at cnt_q == L-1;
    // zero-length phases are never entered
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (start && !illegal) state_d = bias_en ? BIAS : ((K == 32'd0) ? FLUSH : FEED);
            BIAS:        if (bias_acc && bias_cnt == CW'(ARRAY_M - 1)) state_d = feed_entry;
            FEED:        if (cnt_q == k_q - 32'd1) state_d = FLUSH;
            FLUSH:       if (cnt_q == flush_len - 32'd1) state_d = (dw_len == 32'd0) ? DRAIN_STORE : DRAIN_WAIT;
            DRAIN_WAIT:  if (cnt_q == dw_len - 32'd1) state_d = DRAIN_STORE;
            DRAIN_STORE: if (cnt_q == ds_len - 32'd1) state_d = NEXT;
            NEXT:        if (!hold) state_d = last_tile ? DONE : feed_entry;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        if (state_q != IDLE && abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            k_q                 <= '0;
            nrt_q               <= '0;
            nct_q               <= '0;
            row_idx             <= '0;
            col_idx             <= '0;
            bias_cnt            <= '0;
            mode                <= 1'b0;
            busy                <= 1'b0;
            bias_ready          <= 1'b0;
            a_buf_on            <= 1'b0;
            w_buf_on            <= 1'b0;
            operation_signal_in <= 3'b000;
            o_ag_o_on           <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            w_en_bias           <= 1'b0;
            w_index_bias        <= '0;
            w_data_bias         <= '0;
            a_num_rows          <= '0;
            w_num_cols          <= '0;
            a_base_addr         <= '0;
            w_base_addr         <= '0;
            o_base_addr         <= '0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
            bias_cnt            <= (state_d != BIAS) ? '0 : bias_cnt + CW'(bias_acc);
            mode                <= state_d != IDLE;
            busy                <= state_d != IDLE;
            bias_ready          <= state_d == BIAS;
            a_buf_on            <= state_d == FEED;
            w_buf_on            <= state_d == FEED;
            operation_signal_in <= (state_d == FEED || state_d == FLUSH) ? 3'b100 :
                                   (state_d == DRAIN_WAIT || state_d == DRAIN_STORE) ? 3'b110 : 3'b000;
            o_ag_o_on           <= state_d == DRAIN_STORE;
            done                <= state_d == DONE;
            err                 <= (state_q == IDLE) && start && illegal;
            w_en_bias           <= bias_acc;
            w_index_bias        <= bias_acc ? bias_cnt : '0;
            w_data_bias         <= bias_acc ? bias_data : '0;
            if (state_d == IDLE) begin
                a_num_rows  <= '0;
                w_num_cols  <= '0;
                row_idx     <= '0;
                col_idx     <= '0;
                a_base_addr <= '0;
                w_base_addr <= '0;
                o_base_addr <= '0;
            end else if (state_q == IDLE) begin
                k_q        <= K;
                a_num_rows <= tile_rows;
                w_num_cols <= tile_cols;
                nrt_q      <= num_row_tiles;
                nct_q      <= num_col_tiles;
            end else if (state_q == NEXT && state_d != NEXT) begin
                o_base_addr <= o_base_addr + AW'(a_num_rows);
                if (col_idx < nct_q - 8'd1) begin
                    col_idx     <= col_idx + 8'd1;
                    w_base_addr <= w_base_addr + k_q[AW-1:0];
                end else begin
                    col_idx     <= '0;
                    w_base_addr <= '0;
                    row_idx     <= row_idx + 8'd1;
                    a_base_addr <= a_base_addr + k_q[AW-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_os_sequencer.sv
// tb_systolic_os_sequencer: self-checking bench for systolic_os_sequencer (16x16, 10-bit addresses)
module tb_systolic_os_sequencer;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, bias_en = 1'b0, bias_valid = 1'b0, hold = 1'b0, abort = 1'b0;
    logic [31:0] K = '0, bias_data = '0;
    logic [4:0]  tile_rows = '0, tile_cols = '0;
    logic [7:0]  num_row_tiles = '0, num_col_tiles = '0;
    logic        bias_ready, mode, a_buf_on, w_buf_on, w_en_bias, o_ag_o_on, busy, done, err;
    logic [9:0]  a_base_addr, w_base_addr, o_base_addr;
    logic [4:0]  a_num_rows, w_num_cols, w_index_bias;
    logic [2:0]  operation_signal_in;
    logic [31:0] w_data_bias;

    systolic_os_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .K(K), .tile_rows(tile_rows), .tile_cols(tile_cols),
        .num_row_tiles(num_row_tiles), .num_col_tiles(num_col_tiles), .bias_en(bias_en),
        .bias_valid(bias_valid), .bias_data(bias_data), .bias_ready(bias_ready), .hold(hold), .abort(abort),
        .mode(mode), .a_buf_on(a_buf_on), .w_buf_on(w_buf_on), .a_base_addr(a_base_addr),
        .w_base_addr(w_base_addr), .o_base_addr(o_base_addr), .a_num_rows(a_num_rows),
        .w_num_cols(w_num_cols), .operation_signal_in(operation_signal_in), .w_index_bias(w_index_bias),
        .w_data_bias(w_data_bias), .w_en_bias(w_en_bias), .o_ag_o_on(o_ag_o_on), .busy(busy), .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] k;
        logic [4:0]  rows, cols;
        logic [7:0]  nrt, nct;
        logic        ben, btog;
        logic [31:0] bbase;
        logic        exp_err;
        int          feed, flush, dw, ds;
    } vec_t;
    typedef struct { logic [9:0] a, w, o; logic [4:0] rows, cols; int feed, flush, dw, ds; } tile_t;
    typedef struct { logic [4:0] idx; logic [31:0] data; } bw_t;

    vec_t  vecs[$];
    tile_t tile_q[$];
    bw_t   bias_q[$];
    tile_t te;
    bw_t   be;
    int    checks = 0, errors = 0, bwrites = 0, bcnt = 0;
    int    fc, flc, dwc, dsc;
    logic  in_tile = 1'b0, btog = 1'b0, tog = 1'b0;
    logic [31:0] bbase = '0;
    logic [9:0]  sa, sw, so;
    logic [4:0]  sr, scol;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic outs_nonzero();
        return |{bias_ready, mode, a_buf_on, w_buf_on, a_base_addr, w_base_addr, o_base_addr, a_num_rows,
                 w_num_cols, operation_signal_in, w_index_bias, w_data_bias, w_en_bias, o_ag_o_on, busy, done, err};
    endfunction

    function automatic vec_t mk(string nm, int k, int rows, int cols, int nrt, int nct, logic ben, logic bt,
                                logic [31:0] bb, logic e, int feed, int flush, int dw, int ds);
        vec_t v;
        v.name = nm; v.k = 32'(k); v.rows = 5'(rows); v.cols = 5'(cols); v.nrt = 8'(nrt); v.nct = 8'(nct);
        v.ben = ben; v.btog = bt; v.bbase = bb; v.exp_err = e;
        v.feed = feed; v.flush = flush; v.dw = dw; v.ds = ds;
        return v;
    endfunction

    // bias source: expected writes are queued the moment a beat is offered while bias_ready is high
    always @(negedge clk) begin
        tog = ~tog;
        bias_valid = btog ? tog : 1'b1;
        bias_data  = btog ? bbase + 32'(bcnt) : bbase;
        if (!bias_ready) bcnt = 0;
        else if (bias_valid) begin
            bias_q.push_back('{idx: 5'(bcnt), data: bias_data});
            bcnt++;
        end
    end

    // output monitor: bias writes and per-tile phase lengths / base addresses
    always @(negedge clk) begin
        if (w_en_bias) begin
            bwrites++;
            if (bias_q.size() == 0) chk("bias_unexpected", 1, 0);
            else begin
                be = bias_q.pop_front();
                chk("bias_idx", w_index_bias, be.idx);
                chk("bias_data", w_data_bias, be.data);
            end
        end
        if (!busy) in_tile = 1'b0;
        else if (operation_signal_in == 3'b100) begin
            if (!in_tile) begin
                in_tile = 1'b1; fc = 0; flc = 0; dwc = 0; dsc = 0;
                sa = a_base_addr; sw = w_base_addr; so = o_base_addr; sr = a_num_rows; scol = w_num_cols;
            end
            if (a_buf_on) begin
                fc++;
                chk("w_buf_on", w_buf_on, 1);
            end else flc++;
        end else if (operation_signal_in == 3'b110) begin
            if (o_ag_o_on) dsc++; else dwc++;
        end else if (in_tile) begin
            in_tile = 1'b0;
            if (tile_q.size() == 0) chk("tile_unexpected", 1, 0);
            else begin
                te = tile_q.pop_front();
                chk("tile_a_base", sa, te.a);
                chk("tile_w_base", sw, te.w);
                chk("tile_o_base", so, te.o);
                chk("tile_rows_out", sr, te.rows);
                chk("tile_cols_out", scol, te.cols);
                chk("feed_len", fc, te.feed);
                chk("flush_len", flc, te.flush);
                chk("drain_wait_len", dwc, te.dw);
                chk("drain_store_len", dsc, te.ds);
                chk("mode", mode, 1);
            end
        end
    end

    task automatic launch(input vec_t v, input bit push);
        tile_t t;
        @(negedge clk);
        K = v.k; tile_rows = v.rows; tile_cols = v.cols; num_row_tiles = v.nrt; num_col_tiles = v.nct;
        bias_en = v.ben; btog = v.btog; bbase = v.bbase; bwrites = 0;
        if (push && !v.exp_err)
            for (int r = 0; r < int'(v.nrt); r++)
                for (int c = 0; c < int'(v.nct); c++) begin
                    t.a = 10'(r * int'(v.k)); t.w = 10'(c * int'(v.k));
                    t.o = 10'((r * int'(v.nct) + c) * int'(v.rows));
                    t.rows = v.rows; t.cols = v.cols;
                    t.feed = v.feed; t.flush = v.flush; t.dw = v.dw; t.ds = v.ds;
                    tile_q.push_back(t);
                end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input vec_t v);
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({v.name, "_done"}, done, 1);
        @(negedge clk);
        chk({v.name, "_done_once"}, done, 0);
        chk({v.name, "_idle"}, busy, 0);
        chk({v.name, "_tiles_left"}, tile_q.size(), 0);
        chk({v.name, "_bias_left"}, bias_q.size(), 0);
        chk({v.name, "_bias_writes"}, bwrites, v.ben ? 16 : 0);
    endtask

    task automatic run(input vec_t v);
        launch(v, 1'b1);
        chk({v.name, "_err"}, err, v.exp_err);
        if (v.exp_err) begin
            chk({v.name, "_busy"}, busy, 0);
            @(negedge clk);
            chk({v.name, "_err_pulse"}, err, 0);
            chk({v.name, "_busy_after"}, busy, 0);
        end else finish_run(v);
    endtask

    initial begin
        int n, nl;
        vec_t hv, av;
        vecs.push_back(mk("single",   30, 10, 10, 1, 1, 1'b1, 1'b0, 32'hFFFFFFF0, 1'b0, 30, 19, 5, 11));
        vecs.push_back(mk("grid2x3",  30, 16,  8, 2, 3, 1'b0, 1'b0, 32'h0,        1'b0, 30, 23, 0, 17));
        vecs.push_back(mk("bias_tog",  5,  4,  4, 1, 1, 1'b1, 1'b1, 32'hA0000000, 1'b0,  5,  7, 11, 5));
        vecs.push_back(mk("rows17",    5, 17,  4, 1, 1, 1'b0, 1'b0, 32'h0,        1'b1,  0,  0, 0, 0));
        vecs.push_back(mk("ncol0",     5,  4,  4, 1, 0, 1'b0, 1'b0, 32'h0,        1'b1,  0,  0, 0, 0));
        vecs.push_back(mk("k0",        0,  4,  4, 1, 1, 1'b0, 1'b0, 32'h0,        1'b0,  0,  7, 11, 5));
        vecs.push_back(mk("rows15",    3, 15,  1, 1, 1, 1'b0, 1'b0, 32'h0,        1'b0,  3, 15, 0, 16));
        vecs.push_back(mk("rows14",    3, 14,  2, 1, 2, 1'b0, 1'b0, 32'h0,        1'b0,  3, 15, 1, 15));

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_nonzero(), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_outputs", outs_nonzero(), 0);

        foreach (vecs[i]) run(vecs[i]);

        // hold for 5 cycles at the first tile boundary
        hv = mk("hold", 4, 4, 4, 1, 2, 1'b0, 1'b0, 32'h0, 1'b0, 4, 7, 11, 5);
        launch(hv, 1'b1);
        n = 0;
        while (!o_ag_o_on && n < 500) begin @(negedge clk); n++; end
        chk("hold_reach_store", o_ag_o_on, 1);
        while (o_ag_o_on && n < 500) begin @(negedge clk); n++; end
        chk("hold_next_op", operation_signal_in, 3'b000);
        hold = 1'b1;
        nl = 0;
        repeat (5) begin nl++; @(negedge clk); end
        hold = 1'b0;
        while (operation_signal_in == 3'b000 && busy && nl < 50) begin nl++; @(negedge clk); end
        chk("hold_next_len", nl, 6);
        chk("hold_resume_feed", a_buf_on, 1);
        chk("hold_resume_w_base", w_base_addr, 4);
        chk("hold_resume_o_base", o_base_addr, 4);
        finish_run(hv);

        // abort in FEED cycle 10
        av = mk("abort", 30, 4, 4, 1, 1, 1'b0, 1'b0, 32'h0, 1'b0, 30, 7, 11, 5);
        launch(av, 1'b0);
        chk("abort_in_feed", a_buf_on, 1);
        repeat (9) @(negedge clk);
        chk("abort_still_feed", a_buf_on, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outputs", outs_nonzero(), 0);
        n = 0;
        repeat (5) begin @(negedge clk); n += int'(done); end
        chk("abort_no_done", n, 0);
        run(vecs[2]);

        // reset in FLUSH
        launch(av, 1'b0);
        n = 0;
        while (!(operation_signal_in == 3'b100 && !a_buf_on) && n < 200) begin @(negedge clk); n++; end
        chk("reset_reach_flush", {operation_signal_in, a_buf_on}, 4'b1000);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("reset_mid_outputs", outs_nonzero(), 0);
        n = 0;
        repeat (5) begin @(negedge clk); n += int'(done); end
        chk("reset_no_done", n, 0);
        run(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_os_sequencer.md
Name: systolic_os_sequencer

Overview:
- Hardware sequencer for the systolic_system output-stationary (OS) datapath.
- Replaces hand-timed stimulus: loads bias, streams A/W, flushes, drains and stores results.
- Loops over a grid of row × column output tiles and advances buffer base addresses per tile.
- Sits between the host/config registers and systolic_system control inputs.

Parameters:
ARRAY_N, 16, systolic rows (max tile_rows)
ARRAY_M, 16, systolic columns (max tile_cols); also the bias word count
PE_OUT_WIDTH, 32, bias/PE output width
ADDR_WIDTH, 10, buffer address width
OBUF_DELAY, 0, extra o_ag_o_on cycles covering output-buffer pipeline latency (0..7)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  launch pulse, sampled in IDLE only
K  in  32  reduction length (FEED cycles per tile)
tile_rows  in  $clog2(ARRAY_N)+1  active rows per tile
tile_cols  in  $clog2(ARRAY_M)+1  active cols per tile
num_row_tiles  in  8  row-tile count
num_col_tiles  in  8  column-tile count
bias_en  in  1  load bias before the first tile
bias_valid  in  1  bias word valid
bias_data  in  PE_OUT_WIDTH  bias word
bias_ready  out  1  high in BIAS
hold  in  1  stall at tile boundary
abort  in  1  return to IDLE
mode  out  1  constant 1 (OS) while busy, else 0
a_buf_on  out  1  A buffer streaming enable
w_buf_on  out  1  W buffer streaming enable
a_base_addr  out  ADDR_WIDTH  A base address
w_base_addr  out  ADDR_WIDTH  W base address
o_base_addr  out  ADDR_WIDTH  output base address
a_num_rows  out  $clog2(ARRAY_N)+1  = latched tile_rows
w_num_cols  out  $clog2(ARRAY_M)+1  = latched tile_cols
operation_signal_in  out  3  000 idle, 100 OS flow, 110 OS drain
w_index_bias  out  $clog2(ARRAY_M)+1  bias write index
w_data_bias  out  PE_OUT_WIDTH  bias write data
w_en_bias  out  1  bias write enable
o_ag_o_on  out  1  output address generator enable
busy  out  1  not IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-config pulse

Behaviour:
- All outputs registered. When reset=0 at a clk edge: state IDLE, all outputs 0.
- IDLE: on start=1, latch K, tile_rows, tile_cols, tile counts and bias_en.
- Illegal config: any of tile_rows, tile_cols, num_row_tiles, num_col_tiles = 0, tile_rows>ARRAY_N, or tile_cols>ARRAY_M.
  - Pulse err next cycle and stay in IDLE.
- Otherwise go to BIAS if bias_en, else to FEED. Set row_idx=col_idx=0 and all base addresses to 0.
- BIAS:
  - bias_ready=1. Each bias_valid&bias_ready beat drives w_en_bias=1 next cycle, with w_data_bias=bias_data and w_index_bias=beat count.
  - After ARRAY_M beats, go to FEED.
  - Gaps in bias_valid insert idle cycles with w_en_bias=0.
- FEED: K cycles, a_buf_on=w_buf_on=1, op=100. If K=0, skip straight to FLUSH.
- FLUSH: tile_rows+tile_cols-1 cycles, buffers off, op=100.
- DRAIN_WAIT: ARRAY_N-tile_rows-1 cycles, op=110. If tile_rows ≥ ARRAY_N-1, takes 0 cycles.
- DRAIN_STORE: tile_rows+1+OBUF_DELAY cycles, op=110, o_ag_o_on=1.
- NEXT: op=000; stays in NEXT while hold=1. Otherwise, in one cycle:
  - If col_idx < num_col_tiles-1: col_idx++ and w_base_addr += K[ADDR_WIDTH-1:0].
  - Else: col_idx=0, w_base_addr=0, row_idx++ and a_base_addr += K.
  - o_base_addr += tile_rows every tile.
  - All address arithmetic wraps modulo 2^ADDR_WIDTH.
  - After the last tile go to DONE; otherwise go to FEED.
- Bias is loaded once per start, not per tile.
- DONE: done=1 for one cycle, then IDLE.
- start while busy: ignored.
- abort=1 in any non-IDLE state: next cycle IDLE, all control outputs 0, no done.
- abort has priority over hold and state transitions.
- reset=0 mid-operation: same effect as abort.
- Phase counters are 32-bit; a phase length of 1 lasts exactly one cycle.

Test Plan:
- Single tile, ARRAY 16×16, rows=cols=10, K=30, bias_en=1 with bias_valid held high, bias 0xFFFFFFF0 → phase lengths:
  - w_en_bias for 16 cycles, indices 0..15.
  - a/w_buf_on for 30 cycles with op=100, then 19 more cycles at op=100.
  - 5 cycles at op=110 with o_ag_o_on=0, then 11 cycles with o_ag_o_on=1.
  - done 2 cycles later (NEXT, DONE).
- 2×3 tiles, K=30, rows=16, cols=8, bias_en=0:
  - w_base_addr sequence 0,30,60 repeating per row tile; a_base_addr 0 then 30.
  - o_base_addr 0,16,…,80.
  - DRAIN_WAIT skipped each tile.
  - 6 DRAIN_STORE windows of 17 cycles.
- bias_valid toggling 1,0,1,0 → w_index_bias increments only on accepted beats; exactly 16 writes.
- hold=1 for 5 cycles at the first NEXT → NEXT lasts 6 cycles, then FEED resumes with the advanced addresses.
- abort asserted in FEED cycle 10, and separately reset=0 in FLUSH → next cycle IDLE, all outputs 0, no done; a fresh start runs normally.
- Illegal configs, each launched with start: tile_rows=17; num_col_tiles=0; K=0 with rows=cols=4:
  - tile_rows=17 → err pulse, busy stays 0.
  - num_col_tiles=0 → err pulse, busy stays 0.
  - K=0 → FEED skipped, FLUSH 7 cycles.
